// File: rtl/mem_arb_pkg.sv
// Shared encodings for the three-way memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int REQ_DATA = 0;
  localparam int REQ_PTW  = 1;
  localparam int REQ_INST = 2;
  localparam int NUM_REQ  = 3;
  localparam int IDX_W    = 2;
  localparam int CNT_W    = 4;

  typedef logic [IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/mem_arb_age_pick.sv
// Per-requester wait counters and winner select: oldest saturated requester first,
// otherwise fixed priority with index 0 highest.
module mem_arb_age_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] flush,
  input  logic               grant,
  output req_idx_t           winner,
  output logic               any_valid
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [NUM_REQ-1:0]            elig;
  logic [NUM_REQ-1:0]            aged;
  logic [NUM_REQ-1:0][CNT_W-1:0] wait_cnt_q;
  logic [NUM_REQ-1:0][CNT_W-1:0] wait_cnt_d;

  always_comb begin
    elig      = req & ~flush;
    any_valid = |elig;
    winner    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      aged[i] = elig[i] && (wait_cnt_q[i] == MAX_CNT);
    end
    // Descending scan so the lowest matching index is the last assignment.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = req_idx_t'(i);
    end
    if (|aged) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (aged[i]) winner = req_idx_t'(i);
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!req[i] || (grant && winner == req_idx_t'(i))) begin
        wait_cnt_d[i] = '0;
      end else if (elig[i] && wait_cnt_q[i] != MAX_CNT) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between DATA, PTW and INST; one transaction in flight,
// cancelled responses complete on the bus but are not reported.
//   state   | meaning
//   ST_IDLE | no access on the bus; arbitrate eligible requesters
//   ST_BUSY | access for owner held on the bus until valid_mem
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MASK_W   = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        flush,
  input  logic [NUM_REQ-1:0]        wen,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [NUM_REQ*MASK_W-1:0] wmask,
  output logic [NUM_REQ-1:0]        stall,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         address_mem,
  output logic                      ren_mem,
  output logic                      wen_mem,
  output logic [MASK_W-1:0]         wmask_mem,
  output logic [DATA_W-1:0]         wdata_mem,
  input  logic [DATA_W-1:0]         rdata_mem,
  input  logic                      valid_mem
);

  arb_state_e        state_q, state_d;
  req_idx_t          owner_q, owner_d;
  logic              cancelled_q, cancelled_d;
  logic [ADDR_W-1:0] address_mem_q, address_mem_d;
  logic              ren_mem_q, ren_mem_d;
  logic              wen_mem_q, wen_mem_d;
  logic [MASK_W-1:0] wmask_mem_q, wmask_mem_d;
  logic [DATA_W-1:0] wdata_mem_q, wdata_mem_d;

  req_idx_t    winner;
  logic        any_valid;
  logic        grant;
  int unsigned w_idx;

  assign grant = (state_q == ST_IDLE) && any_valid;

  mem_arb_age_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .flush     (flush),
    .grant     (grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    cancelled_d   = cancelled_q;
    address_mem_d = address_mem_q;
    ren_mem_d     = ren_mem_q;
    wen_mem_d     = wen_mem_q;
    wmask_mem_d   = wmask_mem_q;
    wdata_mem_d   = wdata_mem_q;
    done          = '0;
    w_idx         = 32'(winner);
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d       = ST_BUSY;
          owner_d       = winner;
          cancelled_d   = 1'b0;
          address_mem_d = addr[w_idx*ADDR_W +: ADDR_W];
          wdata_mem_d   = wdata[w_idx*DATA_W +: DATA_W];
          wen_mem_d     = wen[w_idx];
          ren_mem_d     = ~wen[w_idx];
          wmask_mem_d   = wen[w_idx] ? wmask[w_idx*MASK_W +: MASK_W] : '0;
        end
      end
      ST_BUSY: begin
        if (flush[owner_q]) cancelled_d = 1'b1;
        if (valid_mem) begin
          // A flush landing on the response cycle cancels just as a sticky one does.
          done[owner_q] = ~cancelled_q & ~flush[owner_q] & ~rst;
          state_d       = ST_IDLE;
          cancelled_d   = 1'b0;
          address_mem_d = '0;
          ren_mem_d     = 1'b0;
          wen_mem_d     = 1'b0;
          wmask_mem_d   = '0;
          wdata_mem_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall       = req & ~done;
  assign rdata       = rdata_mem;
  assign address_mem = address_mem_q;
  assign ren_mem     = ren_mem_q;
  assign wen_mem     = wen_mem_q;
  assign wmask_mem   = wmask_mem_q;
  assign wdata_mem   = wdata_mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      cancelled_q   <= 1'b0;
      address_mem_q <= '0;
      ren_mem_q     <= 1'b0;
      wen_mem_q     <= 1'b0;
      wmask_mem_q   <= '0;
      wdata_mem_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cancelled_q   <= cancelled_d;
      address_mem_q <= address_mem_d;
      ren_mem_q     <= ren_mem_d;
      wen_mem_q     <= wen_mem_d;
      wmask_mem_q   <= wmask_mem_d;
      wdata_mem_q   <= wdata_mem_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, read, write, flush, reset mid-op, aging.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req, flush, wen;
  logic [63:0]  a_r [3];
  logic [63:0]  d_r [3];
  logic [7:0]   m_r [3];
  logic [191:0] addr, wdata;
  logic [23:0]  wmask;
  logic [2:0]   stall, done;
  logic [63:0]  rdata, address_mem, wdata_mem, rdata_mem;
  logic         ren_mem, wen_mem, valid_mem;
  logic [7:0]   wmask_mem;

  int checks = 0;
  int errors = 0;

  assign addr  = {a_r[2], a_r[1], a_r[0]};
  assign wdata = {d_r[2], d_r[1], d_r[0]};
  assign wmask = {m_r[2], m_r[1], m_r[0]};

  always #5 clk = ~clk;

  mem_port_arbiter u_dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flush       (flush),
    .wen         (wen),
    .addr        (addr),
    .wdata       (wdata),
    .wmask       (wmask),
    .stall       (stall),
    .done        (done),
    .rdata       (rdata),
    .address_mem (address_mem),
    .ren_mem     (ren_mem),
    .wen_mem     (wen_mem),
    .wmask_mem   (wmask_mem),
    .wdata_mem   (wdata_mem),
    .rdata_mem   (rdata_mem),
    .valid_mem   (valid_mem)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int       off [3];
  int       busy_cyc;
  int       got [$];
  int       exp_order [5] = '{0, 1, 0, 2, 0};

  initial begin
    rst = 1'b1; req = 3'b111; flush = '0; wen = '0; valid_mem = 1'b0; rdata_mem = '0;
    a_r[0] = 64'hA000; a_r[1] = 64'hB000; a_r[2] = 64'hC000;
    for (int i = 0; i < 3; i++) begin d_r[i] = '0; m_r[i] = 8'hFF; end

    // reset held two cycles with all requesters asserted
    for (int k = 0; k < 2; k++) begin
      nxt(); settle();
      chk("rst_ren", ren_mem, 0);
      chk("rst_wen", wen_mem, 0);
      chk("rst_addr", address_mem, 0);
      chk("rst_wmask", wmask_mem, 0);
      chk("rst_done", done, 0);
      chk("rst_stall", stall, 3'b111);
    end
    rst = 1'b0;
    nxt(); settle();
    chk("first_ren", ren_mem, 1);
    chk("first_addr", address_mem, 64'hA000);
    nxt(); valid_mem = 1'b1; rdata_mem = 64'hCAFE; settle();
    chk("first_done", done, 3'b001);
    chk("first_stall", stall, 3'b110);
    chk("first_rdata", rdata, 64'hCAFE);
    nxt(); valid_mem = 1'b0; req = '0; settle();
    chk("first_idle_ren", ren_mem, 0);
    chk("first_idle_addr", address_mem, 0);

    // single INST read, memory answers 3 cycles after ren_mem
    req = 3'b100; a_r[2] = 64'h1000;
    nxt();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rd_ren", ren_mem, 1);
      chk("rd_addr", address_mem, 64'h1000);
      chk("rd_wmask", wmask_mem, 0);
      chk("rd_done", done, 0);
      nxt();
    end
    valid_mem = 1'b1; rdata_mem = 64'h1234_5678; settle();
    chk("rd_done_valid", done, 3'b100);
    chk("rd_rdata", rdata, 64'h1234_5678);
    nxt(); valid_mem = 1'b0; req = '0; settle();
    chk("rd_idle_ren", ren_mem, 0);

    // DATA write
    req = 3'b001; wen = 3'b001; d_r[0] = 64'hDEADBEEF; m_r[0] = 8'h0F;
    nxt();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("wr_wen", wen_mem, 1);
      chk("wr_ren", ren_mem, 0);
      chk("wr_wdata", wdata_mem, 64'hDEADBEEF);
      chk("wr_wmask", wmask_mem, 8'h0F);
      nxt();
    end
    valid_mem = 1'b1; settle();
    chk("wr_done", done, 3'b001);
    nxt(); valid_mem = 1'b0; req = '0; wen = '0; settle();
    chk("wr_idle_wen", wen_mem, 0);
    chk("wr_idle_wdata", wdata_mem, 0);

    // INST flushed mid-wait; DATA queues behind it
    req = 3'b100; a_r[2] = 64'h2000;
    nxt(); settle();
    chk("fl_ren0", ren_mem, 1);
    nxt(); flush = 3'b100; settle();
    chk("fl_done_pulse", done, 0);
    nxt(); flush = '0; req = 3'b001; settle();
    chk("fl_ren_held", ren_mem, 1);
    chk("fl_addr_held", address_mem, 64'h2000);
    nxt(); valid_mem = 1'b1; settle();
    chk("fl_done_supp", done, 0);
    chk("fl_stall", stall, 3'b001);
    nxt(); valid_mem = 1'b0; settle();
    chk("fl_turnaround", ren_mem, 0);
    nxt(); settle();
    chk("fl_next_ren", ren_mem, 1);
    chk("fl_next_addr", address_mem, 64'hA000);
    nxt(); valid_mem = 1'b1; settle();
    chk("fl_next_done", done, 3'b001);
    nxt(); valid_mem = 1'b0; req = '0; settle();

    // flush with req in IDLE blocks the grant; flush on the valid cycle drops done
    req = 3'b010; flush = 3'b010;
    nxt(); settle();
    chk("flreq_nogrant", ren_mem, 0);
    flush = '0;
    nxt(); settle();
    chk("flreq_grant", ren_mem, 1);
    chk("flreq_addr", address_mem, 64'hB000);
    nxt(); valid_mem = 1'b1; flush = 3'b010; settle();
    chk("flvalid_done", done, 0);
    nxt(); valid_mem = 1'b0; flush = '0; req = '0; settle();

    // stray valid_mem while idle
    valid_mem = 1'b1; settle();
    chk("idle_valid_done", done, 0);
    nxt(); valid_mem = 1'b0;

    // reset while BUSY, response arrives afterwards
    req = 3'b111;
    nxt(); settle();
    chk("rb_busy", ren_mem, 1);
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; req = '0; settle();
    chk("rb_ren", ren_mem, 0);
    chk("rb_addr", address_mem, 0);
    chk("rb_waitcnt", u_dut.u_pick.wait_cnt_q, 0);
    valid_mem = 1'b1; settle();
    chk("rb_done", done, 0);
    nxt(); valid_mem = 1'b0; settle();
    chk("rb_idle_ren", ren_mem, 0);

    // continuous contention, 2-cycle memory, requester re-raises req one cycle after done
    for (int i = 0; i < 3; i++) off[i] = 0;
    busy_cyc = 0;
    for (int cyc = 0; cyc < 60 && got.size() < 5; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (off[i] > 0) begin req[i] = 1'b0; off[i]--; end
        else req[i] = 1'b1;
      end
      if (ren_mem | wen_mem) busy_cyc++;
      else busy_cyc = 0;
      valid_mem = (busy_cyc == 2);
      settle();
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin got.push_back(i); off[i] = 1; end
      end
      nxt();
    end
    req = '0; valid_mem = 1'b0;
    chk("cont_count", got.size(), 5);
    for (int k = 0; k < got.size() && k < 5; k++) begin
      chk($sformatf("cont_order%0d", k), got[k], exp_order[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
